// File: rtl/pipe_if_stage_if.sv
// Bundle of the fetch stage's decode-side and instruction-memory-side signals.
// master = the fetch stage, slave = the surrounding pipeline / memory.
interface pipe_if_stage_if;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] rpc;
  logic [1:0]  pcsource;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] dpc4;
  logic [31:0] inst;
  logic        dvalid;

  modport master (
    input  bpc, jpc, rpc, pcsource, wpcir, imem_ready, imem_rdata,
    output imem_req, imem_addr, pc, dpc4, inst, dvalid
  );

  modport slave (
    output bpc, jpc, rpc, pcsource, wpcir, imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc, dpc4, inst, dvalid
  );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage + IF/ID register with variable-latency imem handshake.
// Optional PIPEIF_DSLOT_SQUASH_EN: the delay-slot fetch after a redirect enters IF/ID as a bubble.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic            clock,
  input logic            reset,
  pipe_if_stage_if.master bus
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        dvalid_q, dvalid_d;
  logic        req_q, req_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic [31:0] pc4, tgt, npc, ld_pc4, ld_inst;
  logic        done, advance, load_real, redirect_now;

`ifdef PIPEIF_DSLOT_SQUASH_EN
  logic squash_q, squash_d;
`endif

  assign pc4          = pc_q + 32'd4;
  // req_q gates completion so imem_ready is ignored while no request is out
  assign done         = (state_q == S_REQ) && req_q && bus.imem_ready;
  assign redirect_now = bus.wpcir && dvalid_q && (bus.pcsource != 2'b00);

  always_comb begin
    tgt = pc4;
    case (bus.pcsource)
      2'b01:   tgt = bus.bpc;
      2'b10:   tgt = bus.rpc;
      2'b11:   tgt = bus.jpc;
      default: tgt = pc4;
    endcase
  end

  always_comb begin
    if (redirect_now)  npc = tgt;
    else if (pend_q)   npc = pend_tgt_q;
    else               npc = pc4;
  end

  always_comb begin
    state_d     = state_q;
    dpc4_d      = dpc4_q;
    inst_d      = inst_q;
    dvalid_d    = dvalid_q;
    hold_pc4_d  = hold_pc4_q;
    hold_inst_d = hold_inst_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    load_real   = 1'b0;
    advance     = 1'b0;
    ld_pc4      = pc4;
    ld_inst     = bus.imem_rdata;
`ifdef PIPEIF_DSLOT_SQUASH_EN
    squash_d    = squash_q;
`endif

    case (state_q)
      S_REQ: begin
        if (done) begin
          if (bus.wpcir) begin
            load_real = 1'b1;
            advance   = 1'b1;
          end else begin
            hold_pc4_d  = pc4;
            hold_inst_d = bus.imem_rdata;
            state_d     = S_HOLD;
          end
        end else if (bus.wpcir) begin
          inst_d   = NOP_INST;
          dvalid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (bus.wpcir) begin
          load_real = 1'b1;
          advance   = 1'b1;
          ld_pc4    = hold_pc4_q;
          ld_inst   = hold_inst_q;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load_real) begin
      dpc4_d   = ld_pc4;
      inst_d   = ld_inst;
      dvalid_d = 1'b1;
    end

`ifdef PIPEIF_DSLOT_SQUASH_EN
    // The slot loaded in the same cycle as the redirect, or the first one after it, is dropped
    if (load_real) begin
      if (squash_q || redirect_now) begin
        inst_d   = NOP_INST;
        dvalid_d = 1'b0;
      end
      squash_d = 1'b0;
    end else if (redirect_now) begin
      squash_d = 1'b1;
    end
`endif

    if (advance) begin
      pend_d = 1'b0;
    end else if (redirect_now) begin
      pend_d     = 1'b1;
      pend_tgt_d = tgt;
    end
  end

  assign pc_d  = advance ? npc : pc_q;
  assign req_d = (state_d == S_REQ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      dpc4_q      <= 32'h0;
      inst_q      <= NOP_INST;
      dvalid_q    <= 1'b0;
      req_q       <= 1'b0;
      hold_pc4_q  <= 32'h0;
      hold_inst_q <= 32'h0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dpc4_q      <= dpc4_d;
      inst_q      <= inst_d;
      dvalid_q    <= dvalid_d;
      req_q       <= req_d;
      hold_pc4_q  <= hold_pc4_d;
      hold_inst_q <= hold_inst_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

`ifdef PIPEIF_DSLOT_SQUASH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) squash_q <= 1'b0;
    else       squash_q <= squash_d;
  end
`endif

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.dpc4      = dpc4_q;
  assign bus.inst      = inst_q;
  assign bus.dvalid    = dvalid_q;

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the decode stage. Supplies dpc4, inst and a valid flag to decode, and consumes decode's bpc, jpc, jump-register target, pcsource and wpcir.
- Owns the PC and a variable-latency instruction-memory handshake.
- Latches a branch/jump redirect when the delay-slot fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word driven into IF/ID for a bubble (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- bpc  in  32  branch target from decode
- jpc  in  32  jump target from decode
- rpc  in  32  jump-register target (forwarded rs value) from decode
- pcsource  in  2  00 pc+4, 01 bpc, 10 rpc, 11 jpc
- wpcir  in  1  1 = decode accepts / PC may advance; 0 = decode stall
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  data valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word
- pc  out  32  current fetch PC
- dpc4  out  32  IF/ID: fetched PC + 4
- inst  out  32  IF/ID: instruction
- dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, dpc4=0, inst=NOP_INST, dvalid=0, imem_req=0.
  - State=S_REQ, hold buffer empty, redirect-pending flag=0.
  - Any outstanding request is abandoned; the memory ignores a request dropped by reset.
- State S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 means "fetch completes"; zero-wait memory gives 1 instruction per cycle.
  - Fetch completes and wpcir=1:
    - IF/ID loads {pc+4, imem_rdata, 1}.
    - pc<=npc; stay in S_REQ.
  - Fetch completes and wpcir=0:
    - imem_rdata and pc+4 go into the hold buffer.
    - IF/ID unchanged; go to S_HOLD.
  - No completion and wpcir=1: IF/ID loads bubble {dpc4 unchanged, NOP_INST, 0}.
  - No completion and wpcir=0: IF/ID unchanged.
- State S_HOLD:
  - imem_req=0; pc unchanged.
  - While wpcir=0: stay.
  - When wpcir=1: IF/ID loads the buffer with dvalid=1, pc<=npc, go to S_REQ.
- Redirect (delay-slot architecture; the fetch after a branch always executes):
  - redirect_now = wpcir & dvalid & (pcsource!=00).
  - Target chosen by pcsource.
- npc priority:
  - redirect_now target;
  - else pending target;
  - else pc+4.
- Redirect bookkeeping:
  - redirect_now and PC not advancing this cycle: capture target, set pending=1.
  - Pending is cleared on the cycle pc advances.
  - redirect_now together with a PC advance: target used directly, pending not set.
  - A second redirect while pending=1 cannot occur, because the delay slot is in flight. If it does occur, the newer target overwrites.
- pcsource is ignored when dvalid=0 or wpcir=0.
- All PC arithmetic is modulo 2^32; pc+4 wraps at 32'hFFFF_FFFC to 0.
- Bits [1:0] of every target are passed through unmodified; there is no alignment check.
- Latency: zero-wait memory gives an instruction in IF/ID 1 cycle after the address is presented.

Optional Feature:
- Macro: PIPEIF_DSLOT_SQUASH_EN.
- Defined:
  - The instruction fetched immediately after a redirect is loaded into IF/ID as a bubble (inst=NOP_INST, dvalid=0), whether it comes directly or via the hold buffer.
  - dpc4 still updates; pc still advances to the target.
  - A squash flag is set with redirect_now/pending and cleared when the squashed slot is consumed.
- Undefined: delay-slot semantics exactly as in Behaviour; no squash logic is instantiated.

Test Plan:
- Sequential fetch, zero-wait memory (imem_ready=1), wpcir=1, RESET_PC=0:
  - pc goes 0,4,8,C;
  - dpc4/inst/dvalid follow 1 cycle later with dvalid=1.
- Wait states (imem_ready asserted every 3rd cycle): 2 bubble cycles (dvalid=0, inst=0) between each instruction; pc advances only on the ready cycles.
- Decode stall:
  - wpcir=0 for 4 cycles while fetch at pc=8 completes;
  - IF/ID frozen, imem_req=0 in S_HOLD;
  - on wpcir=1, IF/ID gets {C, word@8, 1} and pc=C.
- Branch with slow delay slot:
  - dvalid=1, pcsource=01, bpc=0x100 while fetch at 0x14 is pending 2 more cycles;
  - pending latched; after completion pc=0x100, and the 0x14 word is delivered with dvalid=1.
- Jump register with zero-wait memory: pcsource=10, rpc=0x40 → next pc=0x40 with no pending state; pcsource=11, jpc=0x80 works the same.
- Reset asserted mid-wait with imem_req=1: outputs go to reset values asynchronously; after release the first request is at RESET_PC.
- Squash (macro defined): same branch as the slow-delay-slot test → the 0x14 slot appears with dvalid=0, inst=0; the next valid inst comes from 0x100.
